// File: rtl/axi4s_uart_pkg.sv
// rtl/axi4s_uart_pkg.sv - shared framing constants, FSM states and special-byte test
// Used by both the framer and the matching deframer.
package axi4s_uart_pkg;

  localparam logic [7:0] START_BYTE_DEF = 8'h7E;
  localparam logic [7:0] STOP_BYTE_DEF  = 8'h7F;
  localparam logic [7:0] ESC_BYTE_DEF   = 8'h7D;
  localparam logic [7:0] ESC_XOR_DEF    = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ESC,
    ST_DATA,
    ST_DATA_ESC,
    ST_STOP
  } state_t;

  function automatic logic is_special(
    input logic [7:0] b,
    input logic [7:0] start_b,
    input logic [7:0] stop_b,
    input logic [7:0] esc_b
  );
    return (b == start_b) || (b == stop_b) || (b == esc_b);
  endfunction

endpackage

// File: rtl/axi4s_uart_framer.sv
// rtl/axi4s_uart_framer.sv - AXI4-Stream packet to escaped UART byte-stream framer
// Emits START, escaped TID, escaped payload, STOP through a single output register.
module axi4s_uart_framer
  import axi4s_uart_pkg::*;
#(
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter logic [7:0] STOP_BYTE  = STOP_BYTE_DEF,
  parameter logic [7:0] ESC_BYTE   = ESC_BYTE_DEF,
  parameter logic [7:0] ESC_XOR    = ESC_XOR_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        frame_tvalid,
  output logic        frame_tready,
  input  logic [7:0]  frame_tdata,
  input  logic        frame_tlast,
  input  logic [7:0]  frame_tid,
  output logic        tx_byte_tvalid,
  input  logic        tx_byte_tready,
  output logic [7:0]  tx_byte_tdata,
  output logic        tx_byte_tkeep,
  output logic [15:0] frame_count
);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic [7:0]  r_hold;
  logic        r_hold_last;
  logic [15:0] r_frame_count;

  logic        w_load;
  logic        w_out_valid;
  logic [7:0]  w_out_data;
  logic        w_hold_load;
  logic [7:0]  w_hold_data;
  logic        w_hold_last;
  logic        w_count_inc;

  assign w_load         = !r_tvalid || tx_byte_tready;
  assign tx_byte_tvalid = r_tvalid;
  assign tx_byte_tdata  = r_tdata;
  assign tx_byte_tkeep  = 1'b1;
  assign frame_count    = r_frame_count;

  // r_hold carries the latched TID, then any pending escaped byte.
  always_comb begin
    w_next_state = r_state;
    w_out_valid  = 1'b0;
    w_out_data   = r_tdata;
    w_hold_load  = 1'b0;
    w_hold_data  = r_hold;
    w_hold_last  = r_hold_last;
    w_count_inc  = 1'b0;
    frame_tready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_tvalid) begin
          w_out_valid  = 1'b1;
          w_out_data   = START_BYTE;
          w_hold_load  = 1'b1;
          w_hold_data  = frame_tid;
          w_hold_last  = 1'b0;
          w_next_state = ST_ID;
        end
      end
      ST_ID: begin
        w_out_valid = 1'b1;
        if (is_special(r_hold, START_BYTE, STOP_BYTE, ESC_BYTE)) begin
          w_out_data   = ESC_BYTE;
          w_hold_load  = 1'b1;
          w_hold_data  = r_hold ^ ESC_XOR;
          w_next_state = ST_ID_ESC;
        end else begin
          w_out_data   = r_hold;
          w_next_state = ST_DATA;
        end
      end
      ST_ID_ESC: begin
        w_out_valid  = 1'b1;
        w_out_data   = r_hold;
        w_next_state = ST_DATA;
      end
      ST_DATA: begin
        frame_tready = w_load;
        if (frame_tvalid) begin
          w_out_valid = 1'b1;
          if (is_special(frame_tdata, START_BYTE, STOP_BYTE, ESC_BYTE)) begin
            w_out_data   = ESC_BYTE;
            w_hold_load  = 1'b1;
            w_hold_data  = frame_tdata ^ ESC_XOR;
            w_hold_last  = frame_tlast;
            w_next_state = ST_DATA_ESC;
          end else begin
            w_out_data   = frame_tdata;
            w_next_state = frame_tlast ? ST_STOP : ST_DATA;
          end
        end
      end
      ST_DATA_ESC: begin
        w_out_valid  = 1'b1;
        w_out_data   = r_hold;
        w_next_state = r_hold_last ? ST_STOP : ST_DATA;
      end
      ST_STOP: begin
        w_out_valid  = 1'b1;
        w_out_data   = STOP_BYTE;
        w_count_inc  = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Every state change, hold update and output update happens only on a load.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_tvalid      <= 1'b0;
      r_tdata       <= 8'h00;
      r_hold        <= 8'h00;
      r_hold_last   <= 1'b0;
      r_frame_count <= 16'h0000;
    end else if (w_load) begin
      r_state  <= w_next_state;
      r_tvalid <= w_out_valid;
      if (w_out_valid) begin
        r_tdata <= w_out_data;
      end
      if (w_hold_load) begin
        r_hold      <= w_hold_data;
        r_hold_last <= w_hold_last;
      end
      if (w_count_inc) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi4s_uart_framer.sv
// tb/tb_axi4s_uart_framer.sv - scoreboard bench for axi4s_uart_framer
// Stimulus pushes expected bytes; a negedge monitor pops and compares on each handoff.
module tb_axi4s_uart_framer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        frame_tvalid;
  logic        frame_tready;
  logic [7:0]  frame_tdata;
  logic        frame_tlast;
  logic [7:0]  frame_tid;
  logic        tx_byte_tvalid;
  logic        tx_byte_tready = 1'b1;
  logic [7:0]  tx_byte_tdata;
  logic        tx_byte_tkeep;
  logic [15:0] frame_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  bit          rand_ready = 1'b0;
  logic [7:0]  exp_q[$];
  int          hs_cycles[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  axi4s_uart_framer dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .frame_tvalid   (frame_tvalid),
    .frame_tready   (frame_tready),
    .frame_tdata    (frame_tdata),
    .frame_tlast    (frame_tlast),
    .frame_tid      (frame_tid),
    .tx_byte_tvalid (tx_byte_tvalid),
    .tx_byte_tready (tx_byte_tready),
    .tx_byte_tdata  (tx_byte_tdata),
    .tx_byte_tkeep  (tx_byte_tkeep),
    .frame_count    (frame_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cycle++;

  always @(posedge aclk) begin
    #1;
    tx_byte_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, tx_byte_tvalid}, 32'd1);
        check("stall_data_held", {24'd0, tx_byte_tdata}, {24'd0, prev_data});
      end
      if (tx_byte_tvalid && tx_byte_tready) begin
        hs_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_byte_tdata}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'd0, tx_byte_tdata}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = tx_byte_tvalid && !tx_byte_tready;
      prev_data  = tx_byte_tdata;
    end
  end

  function automatic void push_esc(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7F || b == 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void push_frame(input logic [7:0] tid, input logic [7:0] data[$]);
    exp_q.push_back(8'h7E);
    push_esc(tid);
    foreach (data[i]) push_esc(data[i]);
    exp_q.push_back(8'h7F);
  endfunction

  // Called and returns aligned at posedge+1.
  task automatic send_packet(input logic [7:0] tid, input logic [7:0] data[$], input int gap_max);
    int waited;
    for (int i = 0; i < data.size(); i++) begin
      if (gap_max > 0) begin
        frame_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge aclk);
          #1;
        end
      end
      frame_tvalid = 1'b1;
      frame_tdata  = data[i];
      frame_tlast  = (i == data.size() - 1);
      frame_tid    = tid;
      waited = 0;
      forever begin
        @(negedge aclk);
        if (frame_tready) break;
        waited++;
        if (waited > 500) begin
          check("beat_accept_timeout", 32'd0, 32'd1);
          break;
        end
      end
      @(posedge aclk);
      #1;
    end
    frame_tvalid = 1'b0;
    frame_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_q.size() != 0 || tx_byte_tvalid) begin
      @(posedge aclk);
      #1;
      waited++;
      if (waited > 3000) begin
        check("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [15:0] cnt0;
    int waited;
    aresetn      = 1'b0;
    frame_tvalid = 1'b0;
    frame_tdata  = 8'h00;
    frame_tlast  = 1'b0;
    frame_tid    = 8'h00;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", {31'd0, tx_byte_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, tx_byte_tdata}, 32'd0);
    check("rst_frame_tready", {31'd0, frame_tready}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("tkeep", {31'd0, tx_byte_tkeep}, 32'd1);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Test 1: plain packet, five consecutive bytes
    hs_cycles.delete();
    exp_q.push_back(8'h7E); exp_q.push_back(8'h01); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h7F);
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
    send_packet(8'h01, pl, 0);
    wait_drain();
    check("t1_bytes", hs_cycles.size(), 32'd5);
    if (hs_cycles.size() == 5) check("t1_span", hs_cycles[4] - hs_cycles[0], 32'd4);
    check("t1_count", {16'd0, frame_count}, 32'd1);

    // Test 2: escaped TID and payload
    exp_q.push_back(8'h7E); exp_q.push_back(8'h7D); exp_q.push_back(8'h5E);
    exp_q.push_back(8'h7D); exp_q.push_back(8'h5D); exp_q.push_back(8'h7D);
    exp_q.push_back(8'h5F); exp_q.push_back(8'h7F);
    pl.delete(); pl.push_back(8'h7D); pl.push_back(8'h7F);
    send_packet(8'h7E, pl, 0);
    wait_drain();
    check("t2_count", {16'd0, frame_count}, 32'd2);

    // Test 4: back-to-back single-beat packets, no gap
    hs_cycles.delete();
    exp_q.push_back(8'h7E); exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h7F);
    exp_q.push_back(8'h7E); exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h7F);
    pl.delete(); pl.push_back(8'h44);
    send_packet(8'h33, pl, 0);
    pl.delete(); pl.push_back(8'h66);
    send_packet(8'h55, pl, 0);
    wait_drain();
    check("t4_bytes", hs_cycles.size(), 32'd8);
    if (hs_cycles.size() == 8) check("t4_span", hs_cycles[7] - hs_cycles[0], 32'd7);
    check("t4_count", {16'd0, frame_count}, 32'd4);

    // Test 3: random backpressure, random packets with frequent special bytes
    rand_ready = 1'b1;
    cnt0 = frame_count;
    for (int p = 0; p < 200; p++) begin
      logic [7:0] tid;
      int len;
      tid = ($urandom_range(0, 3) == 0) ? 8'h7C + 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      len = $urandom_range(1, 6);
      pl.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) pl.push_back(8'h7C + 8'($urandom_range(1, 3)));
        else pl.push_back(8'($urandom_range(0, 255)));
      end
      push_frame(tid, pl);
      send_packet(tid, pl, 2);
    end
    wait_drain();
    check("t3_count", {16'd0, frame_count}, {16'd0, cnt0 + 16'd200});
    rand_ready = 1'b0;
    @(posedge aclk);
    #1;

    // Test 5: reset mid-packet after TID handoff
    hs_cycles.delete();
    exp_q.push_back(8'h7E); exp_q.push_back(8'hAB);
    frame_tvalid = 1'b1;
    frame_tdata  = 8'h10;
    frame_tlast  = 1'b0;
    frame_tid    = 8'hAB;
    waited = 0;
    forever begin
      @(posedge aclk);
      #2;
      if (hs_cycles.size() >= 2) break;
      waited++;
      if (waited > 100) begin
        check("t5_tid_timeout", hs_cycles.size(), 32'd2);
        break;
      end
    end
    aresetn = 1'b0;
    #1;
    check("t5_tvalid_async", {31'd0, tx_byte_tvalid}, 32'd0);
    check("t5_count", {16'd0, frame_count}, 32'd0);
    check("t5_tready", {31'd0, frame_tready}, 32'd0);
    frame_tvalid = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    hs_cycles.delete();
    exp_q.push_back(8'h7E); exp_q.push_back(8'hC1); exp_q.push_back(8'h9A); exp_q.push_back(8'h7F);
    pl.delete(); pl.push_back(8'h9A);
    send_packet(8'hC1, pl, 0);
    wait_drain();
    check("t5_after_bytes", hs_cycles.size(), 32'd4);
    check("t5_after_count", {16'd0, frame_count}, 32'd1);

    // Test 6: frame_count wrap, preset close to the top
    force dut.r_frame_count = 16'hFFFE;
    @(posedge aclk);
    #1;
    release dut.r_frame_count;
    @(posedge aclk);
    #1;
    check("t6_preset", {16'd0, frame_count}, 32'h0000FFFE);
    pl.delete(); pl.push_back(8'h01);
    push_frame(8'h02, pl);
    send_packet(8'h02, pl, 0);
    wait_drain();
    check("t6_ffff", {16'd0, frame_count}, 32'h0000FFFF);
    push_frame(8'h03, pl);
    send_packet(8'h03, pl, 0);
    wait_drain();
    check("t6_wrap", {16'd0, frame_count}, 32'h00000000);

    repeat (2) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cycle);
    $fatal(1, "timeout");
  end

endmodule
